// File: rtl/rv32i_types.sv
// Shared core types used by the memory-port arbiter.
//   arb_state_t : arbiter FSM states (idle, busy per port, done per port)
//   arb_port_t  : identifies the instruction port (port_i) or the
//                 load/store-queue port (port_d)
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    port_i,
    port_d
  } arb_port_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the instruction-fetch port (i_*) and the load/store-queue
//   port (d_*) onto one downstream memory port (mem_*). One transaction is
//   in flight at a time. The winning request is latched at grant, and the
//   downstream read data is registered before it is returned.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_read/i_write/i_byte_enable/
//   i_address/i_wdata             instruction-port request
//   i_resp/i_rdata                instruction-port completion pulse + data
//   d_read/d_write/d_byte_enable/
//   d_address/d_wdata             load/store-queue request
//   d_resp/d_rdata                load/store-queue completion pulse + data
//   mem_read/mem_write/
//   mem_byte_enable/mem_address/
//   mem_wdata                     downstream request (register driven)
//   mem_resp/mem_rdata            downstream completion pulse + data
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_read,
  input  logic                 i_write,
  input  logic [width/8-1:0]   i_byte_enable,
  input  logic [width-1:0]     i_address,
  input  logic [width-1:0]     i_wdata,
  output logic                 i_resp,
  output logic [width-1:0]     i_rdata,

  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [width/8-1:0]   d_byte_enable,
  input  logic [width-1:0]     d_address,
  input  logic [width-1:0]     d_wdata,
  output logic                 d_resp,
  output logic [width-1:0]     d_rdata,

  output logic                 mem_read,
  output logic                 mem_write,
  output logic [width/8-1:0]   mem_byte_enable,
  output logic [width-1:0]     mem_address,
  output logic [width-1:0]     mem_wdata,
  input  logic                 mem_resp,
  input  logic [width-1:0]     mem_rdata
);

  localparam int be_width = width / 8;

  arb_state_t state;
  arb_state_t state_next;
  arb_port_t  last_grant;
  arb_port_t  grant_port;
  logic       grant;

  logic i_req;
  logic d_req;
  logic busy;

  // Fields of the port selected for grant this cycle.
  logic                sel_read;
  logic                sel_write;
  logic [be_width-1:0] sel_byte_enable;
  logic [width-1:0]    sel_address;
  logic [width-1:0]    sel_wdata;

  // Request register and returned-data register.
  logic                req_read;
  logic                req_write;
  logic [be_width-1:0] req_byte_enable;
  logic [width-1:0]    req_address;
  logic [width-1:0]    req_wdata;
  logic [width-1:0]    rdata_q;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and grant decision. On a tie the port that did not win
  // last time is chosen, which bounds starvation to one transaction.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_port = port_i;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || (last_grant == port_d))) begin
          grant      = 1'b1;
          grant_port = port_i;
          state_next = BUSY_I;
        end else if (d_req) begin
          grant      = 1'b1;
          grant_port = port_d;
          state_next = BUSY_D;
        end
      end
      BUSY_I: begin
        if (mem_resp) begin
          state_next = DONE_I;
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          state_next = DONE_D;
        end
      end
      DONE_I, DONE_D: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request field mux for the port being granted.
  always_comb begin
    sel_read        = i_read;
    sel_write       = i_write;
    sel_byte_enable = i_byte_enable;
    sel_address     = i_address;
    sel_wdata       = i_wdata;
    if (grant_port == port_d) begin
      sel_read        = d_read;
      sel_write       = d_write;
      sel_byte_enable = d_byte_enable;
      sel_address     = d_address;
      sel_wdata       = d_wdata;
    end
  end

  // Datapath registers: request latched at grant, read data at mem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant      <= port_d;
      req_read        <= 1'b0;
      req_write       <= 1'b0;
      req_byte_enable <= '0;
      req_address     <= '0;
      req_wdata       <= '0;
      rdata_q         <= '0;
    end else begin
      if (grant) begin
        // read+write together is treated as a write
        req_read        <= sel_read & ~sel_write;
        req_write       <= sel_write;
        req_byte_enable <= sel_byte_enable;
        req_address     <= sel_address;
        req_wdata       <= sel_wdata;
        last_grant      <= grant_port;
      end
      if (busy && mem_resp) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs decode registered state only; no input-to-output paths.
  assign busy            = (state == BUSY_I) || (state == BUSY_D);
  assign mem_read        = busy & req_read;
  assign mem_write       = busy & req_write;
  assign mem_byte_enable = req_byte_enable;
  assign mem_address     = req_address;
  assign mem_wdata       = req_wdata;

  assign i_resp  = (state == DONE_I);
  assign d_resp  = (state == DONE_D);
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic. A transaction-level model predicts downstream requests
// and upstream responses; a monitor compares them against the DUT.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int BW = W / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [BW-1:0] i_byte_enable, d_byte_enable;
  logic [W-1:0]  i_address, i_wdata, d_address, d_wdata;
  logic          i_resp, d_resp;
  logic [W-1:0]  i_rdata, d_rdata;
  logic          mem_read, mem_write, mem_resp;
  logic [BW-1:0] mem_byte_enable;
  logic [W-1:0]  mem_address, mem_wdata, mem_rdata;

  mem_port_arbiter #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_byte_enable(i_byte_enable),
    .i_address(i_address), .i_wdata(i_wdata), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;   // 0 = instruction port, 1 = load/store port
    logic          rd;
    logic          wr;
    logic [BW-1:0] be;
    logic [W-1:0]  addr;
    logic [W-1:0]  wdata;
    int            cyc;    // cycle in which the downstream request appears
  } txn_t;

  typedef struct {
    int port;
    int cyc;               // cycle in which the upstream resp pulses
  } rsp_t;

  txn_t exp_txn[$];
  rsp_t exp_rsp[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic rst_q = 1'b1;
  logic [W-1:0] exp_rdreg = '0;
  bit   quiet = 0;
  bit   final_chk = 0;

  // Reference model: one transaction at a time; a port may be granted when
  // the arbiter is free; a tie goes to the port not granted last; the
  // response follows one cycle after mem_resp and the arbiter is free again
  // one cycle after that.
  initial begin : ref_model
    bit   m_busy;
    int   m_free_at, m_wait_from, m_port, m_last, p;
    bit   ri, rd;
    txn_t t;
    m_busy = 0; m_free_at = 0; m_wait_from = 0; m_port = 0; m_last = 1;
    forever begin
      @(posedge clk);
      cyc++;
      rst_q = rst;
      if (rst) begin
        m_busy = 0; m_free_at = 0; m_last = 1; exp_rdreg = '0;
      end else if (m_busy) begin
        if (cyc >= m_wait_from && mem_resp) begin
          exp_rdreg = mem_rdata;
          exp_rsp.push_back('{port: m_port, cyc: cyc});
          m_busy = 0;
          m_free_at = cyc + 2;
        end
      end else if (cyc >= m_free_at) begin
        ri = i_read | i_write;
        rd = d_read | d_write;
        if (ri || rd) begin
          p = (ri && rd) ? 1 - m_last : (ri ? 0 : 1);
          if (p == 0)
            t = '{port: 0, rd: i_read & ~i_write, wr: i_write, be: i_byte_enable,
                  addr: i_address, wdata: i_wdata, cyc: cyc};
          else
            t = '{port: 1, rd: d_read & ~d_write, wr: d_write, be: d_byte_enable,
                  addr: d_address, wdata: d_wdata, cyc: cyc};
          exp_txn.push_back(t);
          m_busy = 1; m_wait_from = cyc + 1; m_port = p; m_last = p;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops expectations when the DUT presents a request or response.
  initial begin : monitor
    int   t_rd, r_rd, iw, dw;
    bit   prev_act, act, done;
    txn_t t;
    rsp_t r;
    t_rd = 0; r_rd = 0; iw = 0; dw = 0; prev_act = 0; done = 0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("reset_ctrl", 32'({i_resp, d_resp, mem_read, mem_write, mem_byte_enable}), 0);
        chk("reset_rdata", i_rdata | d_rdata, 0);
        chk("reset_mem_fields", mem_address | mem_wdata, 0);
        t_rd = exp_txn.size(); r_rd = exp_rsp.size();
        prev_act = 0; iw = 0; dw = 0;
      end else begin
        act = mem_read | mem_write;
        if (act && !prev_act) begin
          if (t_rd >= exp_txn.size()) begin
            chk("unexpected_mem_request", 1, 0);
          end else begin
            t = exp_txn[t_rd];
            t_rd++;
            chk("mem_rw_be", 32'({mem_read, mem_write, mem_byte_enable}), 32'({t.rd, t.wr, t.be}));
            chk("mem_address", mem_address, t.addr);
            chk("mem_wdata", mem_wdata, t.wdata);
            chk("mem_req_cycle", cyc, t.cyc);
          end
        end
        prev_act = act;
        if (i_resp || d_resp) begin
          chk("mem_strobes_in_done", 32'(act), 0);
          if (r_rd >= exp_rsp.size()) begin
            chk("unexpected_resp", 32'({i_resp, d_resp}), 0);
          end else begin
            r = exp_rsp[r_rd];
            r_rd++;
            chk("resp_port", 32'({i_resp, d_resp}), (r.port == 0) ? 32'd2 : 32'd1);
            chk("resp_cycle", cyc, r.cyc);
          end
        end
        chk("i_rdata", i_rdata, exp_rdreg);
        chk("d_rdata", d_rdata, exp_rdreg);
        if (quiet) chk("no_resp_when_idle", 32'({i_resp, d_resp}), 0);
        iw = ((i_read | i_write) && !i_resp) ? iw + 1 : 0;
        dw = ((d_read | d_write) && !d_resp) ? dw + 1 : 0;
        if (iw == 80) chk("i_request_timeout", 1, 0);
        if (dw == 80) chk("d_request_timeout", 1, 0);
      end
      if (final_chk && !done) begin
        done = 1;
        chk("all_requests_seen", t_rd, exp_txn.size());
        chk("all_responses_seen", r_rd, exp_rsp.size());
        chk("ports_drained", 32'({i_read | i_write, d_read | d_write}), 0);
      end
    end
  end

  // Stimulus: initiators and downstream responder.
  int           rsp_cnt = -1;
  int           fixed_delay = -1;
  bit           fixed_rd = 0;
  bit           hold_resp = 0;
  logic [W-1:0] fixed_rdata = '0;

  task automatic new_req(input int port);
    int k;
    k = int'($urandom_range(0, 2));
    if (port == 0) begin
      i_read = (k != 1); i_write = (k != 0);
      i_byte_enable = BW'($urandom); i_address = $urandom; i_wdata = $urandom;
    end else begin
      d_read = (k != 1); d_write = (k != 0);
      d_byte_enable = BW'($urandom); d_address = $urandom; d_wdata = $urandom;
    end
  endtask

  task automatic step(input int pct);
    if (mem_resp) begin
      mem_resp = 0;
      mem_rdata = $urandom;
    end else begin
      mem_rdata = $urandom;
      if ((mem_read | mem_write) && !hold_resp) begin
        if (rsp_cnt < 0) rsp_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        if (rsp_cnt == 0) begin
          mem_resp = 1;
          mem_rdata = fixed_rd ? fixed_rdata : $urandom;
          rsp_cnt = -1;
        end else begin
          rsp_cnt--;
        end
      end
    end
    if (i_resp) begin i_read = 0; i_write = 0; end
    if (d_resp) begin d_read = 0; d_write = 0; end
    if (!(i_read | i_write) && int'($urandom_range(0, 99)) < pct) new_req(0);
    if (!(d_read | d_write) && int'($urandom_range(0, 99)) < pct) new_req(1);
  endtask

  task automatic run(input int n, input int pct);
    repeat (n) begin
      @(negedge clk);
      step(pct);
    end
  endtask

  initial begin : main
    rst = 1;
    i_read = 0; i_write = 0; i_byte_enable = '0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_byte_enable = '0; d_address = '0; d_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;

    // Single instruction read, downstream answers 3 cycles after mem_read.
    i_read = 1; i_address = 32'h60; i_byte_enable = '1;
    fixed_delay = 3; fixed_rd = 1; fixed_rdata = 32'h00A00093;
    run(10, 0);
    fixed_delay = -1; fixed_rd = 0;

    // Tie right after reset: I first, then the D write.
    @(negedge clk); rst = 1; rsp_cnt = -1;
    @(negedge clk); rst = 0;
    i_read = 1; i_write = 0; i_address = 32'h100;
    d_read = 0; d_write = 1; d_address = 32'h2000; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'hF;
    run(20, 0);

    // Continuous contention from both ports.
    run(60, 100);
    run(40, 0);

    // Reset while serving D, stray mem_resp in the cycle after reset.
    d_read = 0; d_write = 1; d_address = 32'h3000; d_wdata = 32'h12345678; d_byte_enable = 4'h3;
    hold_resp = 1;
    for (int n = 0; n < 10 && !mem_write; n++) @(negedge clk);
    rst = 1; i_read = 1; i_write = 0; i_address = 32'h340;
    @(negedge clk);
    rst = 0; mem_resp = 1; mem_rdata = 32'hBAD0BAD0; hold_resp = 0; rsp_cnt = -1;
    run(20, 0);

    // Stray mem_resp with nothing pending.
    quiet = 1;
    @(negedge clk); mem_resp = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk); mem_resp = 0;
    repeat (2) @(negedge clk);
    quiet = 0;
    i_read = 1; i_write = 0; i_address = 32'h44;
    run(10, 0);

    // Random traffic, then drain.
    run(1500, 30);
    run(60, 0);

    final_chk = 1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Responder for the core's two memory initiator ports: the instruction-fetch port and the load/store-queue port. Arbitrates them onto a single downstream port that speaks the same read/write/resp protocol, for the unified cache or memory. One transaction is outstanding at a time. Requests are latched at grant, and the response data is registered before it returns to the winning port.

## Interface
Parameters:
- width, 32, data and address width; byte-enable width is width/8

Ports (all outputs are 0 in reset):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_read / i_write  in  1 each  instruction-port request strobes
- i_byte_enable  in  width/8  instruction-port byte enables
- i_address / i_wdata  in  width each  instruction-port address and write data
- i_resp  out  1  one-cycle completion pulse to the instruction port
- i_rdata  out  width  read data, valid while i_resp=1
- d_read / d_write / d_byte_enable / d_address / d_wdata  in  same widths as the i_ set  load/store-queue request
- d_resp / d_rdata  out  1 / width  load/store-queue completion
- mem_read / mem_write  out  1 each  downstream request strobes
- mem_byte_enable  out  width/8  downstream byte enables
- mem_address / mem_wdata  out  width each  downstream address and write data
- mem_resp  in  1  downstream completion pulse
- mem_rdata  in  width  downstream read data, valid while mem_resp=1

## Operation
- Upstream protocol:
  - An initiator raises read or write and holds all request fields stable until it sees resp.
  - resp is a one-cycle pulse.
  - The initiator may present a new request in the cycle after resp.
  - A request is never abandoned.
- The port is "requesting" when read|write is high. If read and write are both high, the request is treated as a write.
- States (arb_state_t): IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE:
  - Sample both ports.
  - If only one is requesting, grant it.
  - If both are requesting, grant the port that is not last_grant (round-robin).
  - On grant:
    - Latch read, write, byte_enable, address and wdata into the request register.
    - Set last_grant to the granted port.
    - Go to BUSY_x.
  - If neither port is requesting, stay in IDLE.
- BUSY_x:
  - mem_read, mem_write, mem_byte_enable, mem_address and mem_wdata are driven from the request register and held stable.
  - On mem_resp: capture mem_rdata into the rdata register and go to DONE_x.
- DONE_x:
  - x_resp=1 for exactly one cycle, with x_rdata equal to the rdata register.
  - The other port's resp stays 0.
  - mem_read and mem_write are 0.
  - Go to IDLE.
- Outside its DONE state, x_rdata holds the rdata register value. Only the resp strobe qualifies it.
- Writes also pass through the DONE state: resp pulses and rdata is don't-care.
- last_grant resets to D, so the first tie after reset goes to I.
- A mem_resp that arrives in IDLE or DONE is ignored and does not change state.
- Reset mid-transaction:
  - State goes to IDLE and all outputs go to 0 in the next cycle.
  - The latched request is discarded and last_grant is set to D.
  - The upstream initiators re-present any pending request after reset.

## Timing
- Request first seen in IDLE at cycle 0 → mem_read/mem_write high from cycle 1.
- mem_resp at cycle k (k ≥ 1) → x_resp at cycle k+1 → IDLE at cycle k+2.
- Minimum upstream latency is 2 cycles from the request seen in IDLE to resp (downstream responds at cycle 1).
- Back-to-back requests from the same port: the new request is seen in IDLE at cycle k+2.
- A port held off by a tie is granted on its next IDLE visit. This bounds starvation to one transaction.
- Downstream outputs are driven only from registers. There is no combinational path from i_*/d_* to mem_*, or from mem_resp to *_resp.

## Structure
- arb_state_t and the port-select enum (port_i, port_d) go in rv32i_types.
- Contents:
  - One state register.
  - One last_grant flop.
  - One request register: read, write, byte_enable, address, wdata.
  - One rdata register.
- No sub-module is needed. The block is a single FSM with its datapath registers.
- It is instantiated at the top level between the core's i_mem_* and lsq_mem_* ports and the cache.

## Test plan
- Single I read, addr 0x60, downstream responds 3 cycles after mem_read rises with 0x00A00093 → mem_address=0x60 with mem_read=1 from cycle 1; i_resp=1 with i_rdata=0x00A00093 one cycle after mem_resp; d_resp stays 0.
- Simultaneous I read 0x100 and D write 0x2000 (wdata 0xDEADBEEF, be 0xF) right after reset → I served first, then D; mem_write=1 with mem_wdata=0xDEADBEEF during D; d_resp pulses once.
- Both ports requesting continuously for 6 transactions → grants alternate I, D, I, D, I, D.
- Downstream changes mem_rdata while the initiator's request is still held in DONE → i_rdata holds the captured value; mem_read=0 in DONE.
- rst asserted in BUSY_D, then mem_resp arrives in the next cycle → all outputs 0; no d_resp; state IDLE; after reset, a tie grants I.
- Stray mem_resp in IDLE with no requests pending → no *_resp; state unchanged.
